// File: rtl/pcie_phy_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pcie_phy_pkg: shared PHY types, ordered-set symbols and classifiers.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pcie_phy_pkg;

  typedef enum logic [1:0] {
    RATE_GEN1 = 2'd0,
    RATE_GEN2 = 2'd1,
    RATE_GEN3 = 2'd2
  } rate_speed_e;

  // Byte 0 (first on the wire) lives in [0].
  typedef logic [15:0][7:0] pcie_ordered_set_t;

  typedef enum logic [2:0] {
    OS_NONE, OS_TS1, OS_TS2, OS_EIEOS, OS_EIOS, OS_SKP
  } os_class_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_COLLECT_G12, ST_COLLECT_G3, ST_SKP_G3
  } os_lane_state_e;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] IDL      = 8'h7C;
  localparam logic [7:0] SKP      = 8'h1C;
  localparam logic [7:0] EIE      = 8'hFC;
  localparam logic [7:0] TS1      = 8'h4A;
  localparam logic [7:0] TS2      = 8'h45;
  localparam logic [7:0] TS1OS    = 8'h1E;
  localparam logic [7:0] TS2OS    = 8'h2D;
  localparam logic [7:0] GEN3_SKP = 8'hAA;
  localparam logic [7:0] SKP_END  = 8'hE1;
  localparam logic [7:0] c_g3_eios = 8'h66;

  function automatic os_class_e classify_g12(input pcie_ordered_set_t os);
    if (os[1] == EIE)      return OS_EIEOS;
    else if (os[6] == TS1) return OS_TS1;
    else if (os[6] == TS2) return OS_TS2;
    else                   return OS_NONE;
  endfunction

  function automatic os_class_e classify_g3(input pcie_ordered_set_t os);
    case (os[0])
      TS1OS:     return OS_TS1;
      TS2OS:     return OS_TS2;
      c_g3_eios: return OS_EIOS;
      8'h00:     return (os[1] == 8'hFF) ? OS_EIEOS : OS_NONE;
      default:   return OS_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/os_lane_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | os_lane_decoder: single-lane ordered-set framer, classifier and          |
// | consecutive-TS counter. Gen3 states built only with OS_GEN3_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module os_lane_decoder
  import pcie_phy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CONSEC_MAX = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  rate_speed_e           curr_data_rate_i,
  input  logic [5:0]            pipe_width_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [3:0]            data_k_i,
  input  logic                  data_valid_i,
  input  logic [1:0]            sync_header_i,
  input  logic                  block_start_i,
  output pcie_ordered_set_t     os_o,
  output logic                  os_valid_o,
  output logic                  ts1_o,
  output logic                  ts2_o,
  output logic                  eieos_o,
  output logic                  eios_o,
  output logic                  skp_o,
  output logic                  idle_o,
  output logic [3:0]            consec_cnt_o,
  output logic                  err_o
);

  localparam logic [3:0] c_cnt_max   = 4'(CONSEC_MAX);
  localparam logic [4:0] c_skp_limit = 5'd24;

  os_lane_state_e    r_state, w_state;
  logic [3:0]        r_bcnt, w_bcnt;
  pcie_ordered_set_t r_buf, w_buf, w_os, r_os;
  logic              r_short, w_short;
  logic [4:0]        r_skp_cnt, w_skp_cnt;
  logic              r_end_seen, w_end_seen;
  logic [1:0]        r_tail, w_tail;
  logic [5:0]        r_width;
  rate_speed_e       r_rate;
  os_class_e         w_cls, r_last_cls;
  logic [119:0]      r_last_ts;
  logic [3:0]        r_cnt;
  logic              w_done, w_err, w_idle, w_zero, w_k;
  logic [7:0]        w_byte;
  logic [2:0]        w_nbytes;
  logic [31:0]       w_data;
  logic              r_os_valid, r_ts1, r_ts2, r_eieos, r_eios, r_skp, r_idle, r_err;

  assign w_data   = 32'(data_i);
  assign w_nbytes = (pipe_width_i[5:3] > 3'd4) ? 3'd4 : pipe_width_i[5:3];

`ifndef OS_GEN3_EN
  logic w_unused_sync;
  assign w_unused_sync = ^sync_header_i;
`endif

  always_comb begin
    w_state = r_state;   w_bcnt = r_bcnt;       w_buf = r_buf;   w_short = r_short;
    w_skp_cnt = r_skp_cnt; w_end_seen = r_end_seen; w_tail = r_tail;
    w_done = 1'b0; w_cls = OS_NONE; w_os = '0; w_err = 1'b0; w_idle = 1'b0;
    w_zero = 1'b1; w_byte = '0; w_k = 1'b0;
    // The width is frozen once a set is in flight; a change aborts it.
    if (r_state != ST_IDLE && pipe_width_i != r_width) begin
      w_state = ST_IDLE;
      w_bcnt  = '0;
      w_err   = 1'b1;
    end else if (data_valid_i) begin
      if (curr_data_rate_i != RATE_GEN3) begin
        if (r_state != ST_IDLE && r_state != ST_COLLECT_G12) begin
          w_state = ST_IDLE;
          w_bcnt  = '0;
        end
        for (int j = 0; j < 4; j++) begin
          if (3'(j) < w_nbytes) begin
            w_byte = w_data[j*8 +: 8];
            w_k    = data_k_i[j];
            if (w_byte != 8'h00 || w_k) w_zero = 1'b0;
            if (w_k && w_byte == COM) begin
              if (w_state == ST_COLLECT_G12) w_err = 1'b1;
              w_buf    = '0;
              w_buf[0] = COM;
              w_bcnt   = 4'd1;
              w_short  = 1'b0;
              w_state  = ST_COLLECT_G12;
            end else if (w_state == ST_COLLECT_G12) begin
              w_buf[w_bcnt] = w_byte;
              if (w_bcnt == 4'd1) w_short = w_k && (w_byte == IDL || w_byte == SKP);
              if ((w_short && w_bcnt == 4'd3) || w_bcnt == 4'd15) begin
                w_done  = 1'b1;
                w_os    = w_buf;
                w_cls   = w_short ? ((w_buf[1] == IDL) ? OS_EIOS : OS_SKP) : classify_g12(w_buf);
                w_state = ST_IDLE;
                w_bcnt  = '0;
              end else begin
                w_bcnt = w_bcnt + 4'd1;
              end
            end
          end
        end
        w_idle = (r_state == ST_IDLE) && w_zero;
      end else begin
`ifdef OS_GEN3_EN
        if (r_state == ST_COLLECT_G12) begin
          w_state = ST_IDLE;
          w_bcnt  = '0;
        end
        if (block_start_i) begin
          if (r_state == ST_COLLECT_G3 || r_state == ST_SKP_G3) w_err = 1'b1;
          w_state = ST_IDLE;
          w_bcnt  = '0;
          if (sync_header_i == 2'b10) begin
            w_buf      = '0;
            w_skp_cnt  = '0;
            w_end_seen = 1'b0;
            w_tail     = '0;
            w_state    = (w_data[7:0] == GEN3_SKP) ? ST_SKP_G3 : ST_COLLECT_G3;
          end else if (sync_header_i != 2'b01) begin
            w_err = 1'b1;
          end
        end
        for (int j = 0; j < 4; j++) begin
          if (3'(j) < w_nbytes) begin
            w_byte = w_data[j*8 +: 8];
            if (w_state == ST_COLLECT_G3) begin
              w_buf[w_bcnt] = w_byte;
              if (w_bcnt == 4'd15) begin
                w_done  = 1'b1;
                w_os    = w_buf;
                w_cls   = classify_g3(w_buf);
                w_state = ST_IDLE;
                w_bcnt  = '0;
              end else begin
                w_bcnt = w_bcnt + 4'd1;
              end
            end else if (w_state == ST_SKP_G3) begin
              if (!w_skp_cnt[4]) w_buf[w_skp_cnt[3:0]] = w_byte;
              w_skp_cnt = w_skp_cnt + 5'd1;
              if (w_end_seen) begin
                w_tail = w_tail + 2'd1;
                if (w_tail == 2'd3) begin
                  w_done  = 1'b1;
                  w_os    = w_buf;
                  w_cls   = OS_SKP;
                  w_state = ST_IDLE;
                end
              end else if (w_byte == SKP_END) begin
                w_end_seen = 1'b1;
              end else if (w_skp_cnt == c_skp_limit) begin
                w_err   = 1'b1;
                w_state = ST_IDLE;
              end
            end
          end
        end
`else
        w_state = ST_IDLE;
        w_bcnt  = '0;
        if (block_start_i) w_err = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_bcnt     <= '0;
      r_buf      <= '0;
      r_short    <= 1'b0;
      r_skp_cnt  <= '0;
      r_end_seen <= 1'b0;
      r_tail     <= '0;
      r_width    <= '0;
      r_rate     <= RATE_GEN1;
      r_last_cls <= OS_NONE;
      r_last_ts  <= '0;
      r_cnt      <= '0;
      r_os       <= '0;
      r_os_valid <= 1'b0;
      r_ts1      <= 1'b0;
      r_ts2      <= 1'b0;
      r_eieos    <= 1'b0;
      r_eios     <= 1'b0;
      r_skp      <= 1'b0;
      r_idle     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_bcnt     <= w_bcnt;
      r_buf      <= w_buf;
      r_short    <= w_short;
      r_skp_cnt  <= w_skp_cnt;
      r_end_seen <= w_end_seen;
      r_tail     <= w_tail;
      r_rate     <= curr_data_rate_i;
      if (r_state == ST_IDLE) r_width <= pipe_width_i;
      if (w_done) r_os <= w_os;
      r_os_valid <= w_done;
      r_ts1      <= w_done && (w_cls == OS_TS1);
      r_ts2      <= w_done && (w_cls == OS_TS2);
      r_eieos    <= w_done && (w_cls == OS_EIEOS);
      r_eios     <= w_done && (w_cls == OS_EIOS);
      r_skp      <= w_done && (w_cls == OS_SKP);
      r_idle     <= w_idle;
      r_err      <= w_err;
      // Identity of a TS ignores symbol 0 (COM / block type already matched).
      if (w_err || curr_data_rate_i != r_rate) begin
        r_cnt      <= '0;
        r_last_cls <= OS_NONE;
      end else if (w_done) begin
        case (w_cls)
          OS_TS1, OS_TS2: begin
            if (w_cls == r_last_cls && w_os[15:1] == r_last_ts)
              r_cnt <= (r_cnt >= c_cnt_max) ? c_cnt_max : r_cnt + 4'd1;
            else
              r_cnt <= 4'd1;
            r_last_ts  <= w_os[15:1];
            r_last_cls <= w_cls;
          end
          OS_EIOS, OS_EIEOS: begin
            r_cnt      <= '0;
            r_last_cls <= OS_NONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign os_o         = r_os;
  assign os_valid_o   = r_os_valid;
  assign ts1_o        = r_ts1;
  assign ts2_o        = r_ts2;
  assign eieos_o      = r_eieos;
  assign eios_o       = r_eios;
  assign skp_o        = r_skp;
  assign idle_o       = r_idle;
  assign err_o        = r_err;
  assign consec_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/os_rx_lane_decoder_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | os_rx_lane_decoder_array: NUM_LANES independent ordered-set decoders.    |
// | Gen3 framing is built when OS_GEN3_EN is defined. Revision: 1.0          |
// +--------------------------------------------------------------------------+
module os_rx_lane_decoder_array
  import pcie_phy_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CONSEC_MAX = 15
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  rate_speed_e                     curr_data_rate_i,
  input  logic [5:0]                      pipe_width_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_LANES*4-1:0]          data_k_i,
  input  logic [NUM_LANES-1:0]            data_valid_i,
  input  logic [NUM_LANES*2-1:0]          sync_header_i,
  input  logic [NUM_LANES-1:0]            block_start_i,
  output pcie_ordered_set_t [NUM_LANES-1:0] os_o,
  output logic [NUM_LANES-1:0]            os_valid_o,
  output logic [NUM_LANES-1:0]            ts1_o,
  output logic [NUM_LANES-1:0]            ts2_o,
  output logic [NUM_LANES-1:0]            eieos_o,
  output logic [NUM_LANES-1:0]            eios_o,
  output logic [NUM_LANES-1:0]            skp_o,
  output logic [NUM_LANES-1:0]            idle_o,
  output logic [NUM_LANES*4-1:0]          consec_cnt_o,
  output logic [NUM_LANES-1:0]            err_o
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    os_lane_decoder #(
      .DATA_WIDTH (DATA_WIDTH),
      .CONSEC_MAX (CONSEC_MAX)
    ) u_lane (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .curr_data_rate_i (curr_data_rate_i),
      .pipe_width_i     (pipe_width_i),
      .data_i           (data_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .data_k_i         (data_k_i[g*4 +: 4]),
      .data_valid_i     (data_valid_i[g]),
      .sync_header_i    (sync_header_i[g*2 +: 2]),
      .block_start_i    (block_start_i[g]),
      .os_o             (os_o[g]),
      .os_valid_o       (os_valid_o[g]),
      .ts1_o            (ts1_o[g]),
      .ts2_o            (ts2_o[g]),
      .eieos_o          (eieos_o[g]),
      .eios_o           (eios_o[g]),
      .skp_o            (skp_o[g]),
      .idle_o           (idle_o[g]),
      .consec_cnt_o     (consec_cnt_o[g*4 +: 4]),
      .err_o            (err_o[g])
    );
  end

endmodule
`default_nettype wire
